// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: widths, bubble encoding, RV64 opcodes
// and the fetch FSM state type.
package pipeline_pkg;

    localparam int XLEN = 64;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_OP_IMM32 = 7'h1b;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_OP32     = 7'h3b;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6f;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    typedef enum logic [1:0] {
        RESET,
        REQ,
        WAIT,
        HOLD
    } if_state_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port: valid/ready request, valid-only in-order
// response.
interface if_stage_if #(
    parameter int XLEN = 64
) ();

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_hold_buf.sv
// One-entry {pc, instr} buffer parking a fetched word while decode
// is stalled with IF/ID occupied.
module if_hold_buf #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= in_pc;
            instr <= in_instr;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request,
// and the IF/ID register with stall/redirect handling.
module if_stage #(
    parameter int              XLEN     = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    if_stage_if.master      imem,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic [6:0]      ifid_opcode
);

    import pipeline_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    if_state_t       state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] fetch_pc;
    logic            req_valid;
    logic            stale;

    logic            hs;
    logic            rsp;
    logic            redir;
    logic            rsp_take;
    logic            to_ifid;
    logic [XLEN-1:0] tgt_pc;

    logic            hb_valid;
    logic [XLEN-1:0] hb_pc;
    logic [31:0]     hb_instr;
    logic            hb_load;
    logic            hb_drain;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = req_addr;

    assign tgt_pc   = redirect_pc & ALIGN_MASK;
    assign redir    = redirect_valid && (state != RESET);
    assign hs       = (state == REQ) && req_valid
                      && imem.imem_req_ready;
    assign rsp      = (state == WAIT) && imem.imem_rsp_valid;
    assign rsp_take = rsp && !stale && !redir;
    assign to_ifid  = rsp_take && (!ifid_valid || !stall);
    assign hb_load  = rsp_take && ifid_valid && stall;
    assign hb_drain = (state == HOLD) && hb_valid
                      && !stall && !redir;

    if_hold_buf #(
        .XLEN(XLEN)
    ) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (hb_load),
        .drain   (hb_drain),
        .clear   (redir),
        .in_pc   (fetch_pc),
        .in_instr(imem.imem_rsp_data),
        .valid   (hb_valid),
        .pc      (hb_pc),
        .instr   (hb_instr)
    );

    // A stale request keeps pc at the redirect target when accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RESET;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            fetch_pc  <= '0;
            req_valid <= 1'b0;
            stale     <= 1'b0;
        end else begin
            unique case (state)
                RESET: begin
                    state     <= REQ;
                    req_valid <= 1'b1;
                    req_addr  <= pc;
                end
                REQ: begin
                    if (redir)
                        pc <= tgt_pc;
                    else if (hs && !stale)
                        pc <= pc + XLEN'(4);
                    if (hs) begin
                        state     <= WAIT;
                        req_valid <= 1'b0;
                        fetch_pc  <= req_addr;
                        stale     <= stale || redir;
                    end else if (redir) begin
                        stale <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redir) begin
                        pc <= tgt_pc;
                        if (imem.imem_rsp_valid) begin
                            stale     <= 1'b0;
                            state     <= REQ;
                            req_valid <= 1'b1;
                            req_addr  <= tgt_pc;
                        end else begin
                            stale <= 1'b1;
                        end
                    end else if (rsp) begin
                        stale <= 1'b0;
                        if (hb_load) begin
                            state <= HOLD;
                        end else begin
                            state     <= REQ;
                            req_valid <= 1'b1;
                            req_addr  <= pc;
                        end
                    end
                end
                HOLD: begin
                    if (redir) begin
                        pc        <= tgt_pc;
                        state     <= REQ;
                        req_valid <= 1'b1;
                        req_addr  <= tgt_pc;
                    end else if (!stall) begin
                        state     <= REQ;
                        req_valid <= 1'b1;
                        req_addr  <= pc;
                    end
                end
                default: state <= RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_valid  <= 1'b0;
            ifid_pc     <= '0;
            ifid_instr  <= BUBBLE_INSTR;
            ifid_opcode <= '0;
        end else if (redir) begin
            ifid_valid  <= 1'b0;
            ifid_instr  <= BUBBLE_INSTR;
            ifid_opcode <= '0;
        end else if (to_ifid) begin
            ifid_valid  <= 1'b1;
            ifid_pc     <= fetch_pc;
            ifid_instr  <= imem.imem_rsp_data;
            ifid_opcode <= opcode_of(imem.imem_rsp_data);
        end else if (hb_drain) begin
            ifid_valid  <= 1'b1;
            ifid_pc     <= hb_pc;
            ifid_instr  <= hb_instr;
            ifid_opcode <= opcode_of(hb_instr);
        end else if (!stall) begin
            ifid_valid  <= 1'b0;
            ifid_instr  <= BUBBLE_INSTR;
            ifid_opcode <= '0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a zero-wait instruction memory
// whose word at address a is {a[24:0], 7'h13}.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ifid_valid;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [6:0]  ifid_opcode;

    logic        ready_en;
    logic        rsp_en;
    logic        mem_pend;
    logic [24:0] mem_addr;

    int n_cmp;
    int n_err;

    if_stage_if #(.XLEN(64)) mif ();

    if_stage #(
        .XLEN    (64),
        .RESET_PC(64'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (mif.master),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_opcode   (ifid_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mif.imem_req_ready = ready_en;
    assign mif.imem_rsp_valid = mem_pend && rsp_en;
    assign mif.imem_rsp_data  = {mem_addr, 7'h13};

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_pend <= 1'b0;
        end else begin
            if (mif.imem_rsp_valid)
                mem_pend <= 1'b0;
            if (mif.imem_req_valid && mif.imem_req_ready) begin
                mem_pend <= 1'b1;
                mem_addr <= mif.imem_req_addr[24:0];
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_cmp++; if (mif.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got %h want 0", mif.imem_req_valid); end
        n_cmp++; if (mif.imem_req_addr !== 64'h0) begin n_err++; $display("FAIL rst_req_addr got %h want 0", mif.imem_req_addr); end
        n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rst_ifid_valid got %h want 0", ifid_valid); end
        n_cmp++; if (ifid_pc !== 64'h0) begin n_err++; $display("FAIL rst_ifid_pc got %h want 0", ifid_pc); end
        n_cmp++; if (ifid_instr !== 32'h0) begin n_err++; $display("FAIL rst_ifid_instr got %h want 0", ifid_instr); end
        n_cmp++; if (ifid_opcode !== 7'h0) begin n_err++; $display("FAIL rst_ifid_opcode got %h want 0", ifid_opcode); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (mif.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid got %h want 1", mif.imem_req_valid); end
        n_cmp++; if (mif.imem_req_addr !== 64'h0) begin n_err++; $display("FAIL first_req_addr got %h want 0", mif.imem_req_addr); end
    endtask

    task automatic test_startup();
        step();
        n_cmp++; if (mif.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL wait_req_valid got %h want 0", mif.imem_req_valid); end
        step();
        n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL su0_valid got %h want 1", ifid_valid); end
        n_cmp++; if (ifid_pc !== 64'h0) begin n_err++; $display("FAIL su0_pc got %h want 0", ifid_pc); end
        n_cmp++; if (ifid_instr !== 32'h13) begin n_err++; $display("FAIL su0_instr got %h want 13", ifid_instr); end
        n_cmp++; if (ifid_opcode !== 7'h13) begin n_err++; $display("FAIL su0_opcode got %h want 13", ifid_opcode); end
        n_cmp++; if (mif.imem_req_addr !== 64'h4) begin n_err++; $display("FAIL su_addr4 got %h want 4", mif.imem_req_addr); end
        step();
        n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL su_bubble got %h want 0", ifid_valid); end
        step();
        n_cmp++; if (ifid_pc !== 64'h4) begin n_err++; $display("FAIL su1_pc got %h want 4", ifid_pc); end
        n_cmp++; if (ifid_instr !== 32'h213) begin n_err++; $display("FAIL su1_instr got %h want 213", ifid_instr); end
        n_cmp++; if (mif.imem_req_addr !== 64'h8) begin n_err++; $display("FAIL su_addr8 got %h want 8", mif.imem_req_addr); end
    endtask

    task automatic test_backpressure();
        ready_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (mif.imem_req_addr !== 64'h8) begin n_err++; $display("FAIL bp_addr[%0d] got %h want 8", i, mif.imem_req_addr); end
            n_cmp++; if (mif.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %h want 1", i, mif.imem_req_valid); end
        end
        ready_en = 1'b1;
        step();
        n_cmp++; if (mif.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_accept got %h want 0", mif.imem_req_valid); end
        step();
        n_cmp++; if (ifid_pc !== 64'h8) begin n_err++; $display("FAIL bp_ifid_pc got %h want 8", ifid_pc); end
        n_cmp++; if (mif.imem_req_addr !== 64'hc) begin n_err++; $display("FAIL bp_next_addr got %h want c", mif.imem_req_addr); end
    endtask

    task automatic test_stall_hold();
        stall = 1'b1;
        step();
        n_cmp++; if (ifid_pc !== 64'h8 || ifid_valid !== 1'b1) begin n_err++; $display("FAIL st_keep got %h/%h want 8/1", ifid_pc, ifid_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (mif.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL st_noreq[%0d] got %h want 0", i, mif.imem_req_valid); end
            n_cmp++; if (ifid_pc !== 64'h8 || ifid_valid !== 1'b1) begin n_err++; $display("FAIL st_hold[%0d] got %h/%h want 8/1", i, ifid_pc, ifid_valid); end
        end
        stall = 1'b0;
        step();
        n_cmp++; if (ifid_pc !== 64'hc || ifid_valid !== 1'b1) begin n_err++; $display("FAIL st_drain_pc got %h/%h want c/1", ifid_pc, ifid_valid); end
        n_cmp++; if (ifid_instr !== 32'h613) begin n_err++; $display("FAIL st_drain_instr got %h want 613", ifid_instr); end
        n_cmp++; if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== 64'h10) begin n_err++; $display("FAIL st_resume got %h/%h want 1/10", mif.imem_req_valid, mif.imem_req_addr); end
        step();
        step();
        n_cmp++; if (ifid_pc !== 64'h10 || ifid_instr !== 32'h813) begin n_err++; $display("FAIL st_next got %h/%h want 10/813", ifid_pc, ifid_instr); end
    endtask

    task automatic test_redirect_wait();
        stall = 1'b1;
        step();
        rsp_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h103;
        step();
        n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rw_flush got %h want 0", ifid_valid); end
        n_cmp++; if (ifid_instr !== 32'h0 || ifid_opcode !== 7'h0) begin n_err++; $display("FAIL rw_bubble got %h/%h want 0/0", ifid_instr, ifid_opcode); end
        n_cmp++; if (mif.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_noreq got %h want 0", mif.imem_req_valid); end
        redirect_valid = 1'b0;
        stall = 1'b0;
        rsp_en = 1'b1;
        step();
        n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rw_drop got %h want 0", ifid_valid); end
        n_cmp++; if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== 64'h100) begin n_err++; $display("FAIL rw_target got %h/%h want 1/100", mif.imem_req_valid, mif.imem_req_addr); end
        step();
        step();
        n_cmp++; if (ifid_pc !== 64'h100 || ifid_instr !== 32'h8013 || ifid_valid !== 1'b1) begin n_err++; $display("FAIL rw_fetch got %h/%h/%h want 100/8013/1", ifid_pc, ifid_instr, ifid_valid); end
    endtask

    task automatic test_redirect_stall_rsp();
        stall = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        step();
        n_cmp++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin n_err++; $display("FAIL rsr_flush got %h/%h want 0/0", ifid_valid, ifid_instr); end
        n_cmp++; if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== 64'h200) begin n_err++; $display("FAIL rsr_target got %h/%h want 1/200", mif.imem_req_valid, mif.imem_req_addr); end
        redirect_valid = 1'b0;
        stall = 1'b0;
        step();
        step();
        n_cmp++; if (ifid_pc !== 64'h200 || ifid_instr !== 32'h10013) begin n_err++; $display("FAIL rsr_fetch got %h/%h want 200/10013", ifid_pc, ifid_instr); end
    endtask

    task automatic test_redirect_req();
        ready_en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h302;
        step();
        n_cmp++; if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== 64'h204) begin n_err++; $display("FAIL rq_old_addr got %h/%h want 1/204", mif.imem_req_valid, mif.imem_req_addr); end
        n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rq_flush got %h want 0", ifid_valid); end
        redirect_valid = 1'b0;
        ready_en = 1'b1;
        step();
        step();
        n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rq_drop got %h want 0", ifid_valid); end
        n_cmp++; if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== 64'h300) begin n_err++; $display("FAIL rq_target got %h/%h want 1/300", mif.imem_req_valid, mif.imem_req_addr); end
        step();
        step();
        n_cmp++; if (ifid_pc !== 64'h300 || ifid_instr !== 32'h18013) begin n_err++; $display("FAIL rq_fetch got %h/%h want 300/18013", ifid_pc, ifid_instr); end
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        step();
        step();
        n_cmp++; if (mif.imem_req_valid !== 1'b0 || ifid_pc !== 64'h300) begin n_err++; $display("FAIL rm_hold got %h/%h want 0/300", mif.imem_req_valid, ifid_pc); end
        rst_n = 1'b0;
        stall = 1'b0;
        step();
        n_cmp++; if (mif.imem_req_valid !== 1'b0 || mif.imem_req_addr !== 64'h0) begin n_err++; $display("FAIL rm_req got %h/%h want 0/0", mif.imem_req_valid, mif.imem_req_addr); end
        n_cmp++; if (ifid_valid !== 1'b0 || ifid_pc !== 64'h0) begin n_err++; $display("FAIL rm_ifid got %h/%h want 0/0", ifid_valid, ifid_pc); end
        n_cmp++; if (ifid_instr !== 32'h0 || ifid_opcode !== 7'h0) begin n_err++; $display("FAIL rm_instr got %h/%h want 0/0", ifid_instr, ifid_opcode); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (mif.imem_req_valid !== 1'b1 || mif.imem_req_addr !== 64'h0) begin n_err++; $display("FAIL rm_restart got %h/%h want 1/0", mif.imem_req_valid, mif.imem_req_addr); end
        step();
        step();
        n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h0 || ifid_instr !== 32'h13) begin n_err++; $display("FAIL rm_fetch got %h/%h/%h want 1/0/13", ifid_valid, ifid_pc, ifid_instr); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        ready_en = 1'b1;
        rsp_en = 1'b1;
        test_reset();
        test_startup();
        test_backpressure();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_stall_rsp();
        test_redirect_req();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
